// File: rtl/flappy_pkg.sv
// Shared types and default constants for the flappy game blocks.
// Imported by the flap controller and its interface users.
package flappy_pkg;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLAP,
    DEAD
  } state_t;

  localparam int ROWS       = 8;
  localparam int START_ROW  = 4;
  localparam int CLIMB_ROWS = 2;
  localparam int TICK_DIV   = 25000000;
endpackage

// File: rtl/flap_controller_if.sv
// Press/collision inputs and bird status outputs of the flap controller.
// master drives the game inputs; slave is the controller.
interface flap_controller_if #(
  parameter int ROW_W = 3
);
  logic             press;
  logic             collision;
  logic [ROW_W-1:0] bird_row;
  logic             playing;
  logic             game_over;
  logic             step;

  modport master (
    output press, collision,
    input  bird_row, playing, game_over, step
  );

  modport slave (
    input  press, collision,
    output bird_row, playing, game_over, step
  );
endinterface

// File: rtl/flap_controller_tick_divider.sv
// Free-running step divider: pulses tick on the last count of each period.
// Reusable for pipe scrolling.
module tick_divider #(
  parameter int DIV = 4,
  parameter int W   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [W-1:0] cnt;
  logic         last;

  assign last = cnt == W'(DIV - 1);
  assign tick = en && last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/flap_controller.sv
// Game sequencer: IDLE/RUN/FLAP/DEAD state, gravity and climb on the bird row.
// Consumes the debounced press pulse and the pipe collision level.
module flap_controller #(
  parameter int ROWS       = flappy_pkg::ROWS,
  parameter int ROW_W      = 3,
  parameter int START_ROW  = flappy_pkg::START_ROW,
  parameter int CLIMB_ROWS = flappy_pkg::CLIMB_ROWS,
  parameter int TICK_DIV   = flappy_pkg::TICK_DIV,
  parameter int TICK_W     = 25
) (
  input logic              clk,
  input logic              reset,
  flap_controller_if.slave bus
);
  import flappy_pkg::*;

  localparam int CW = $clog2(CLIMB_ROWS + 1);

  state_t           state, state_n;
  logic [ROW_W-1:0] row, row_n;
  logic [CW-1:0]    climb_cnt, climb_n;
  logic             step_q;
  logic             tick;
  logic             run;

  assign run = (state == RUN) || (state == FLAP);

  // Counter sits at zero outside play, so entry to RUN starts a full period
  tick_divider #(
    .DIV (TICK_DIV),
    .W   (TICK_W)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .clr   (!run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= ROW_W'(START_ROW);
      climb_cnt <= '0;
      step_q    <= 1'b0;
    end else begin
      state     <= state_n;
      row       <= row_n;
      climb_cnt <= climb_n;
      step_q    <= tick;
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    climb_n = climb_cnt;
    unique case (state)
      IDLE: begin
        row_n = ROW_W'(START_ROW);
        if (bus.press) state_n = RUN;
      end
      RUN: begin
        if (bus.collision) begin
          state_n = DEAD;
        end else if (bus.press) begin
          state_n = FLAP;
          climb_n = CW'(CLIMB_ROWS);
        end else if (tick) begin
          if (row == '0) state_n = DEAD;
          else row_n = row - ROW_W'(1);
        end
      end
      FLAP: begin
        if (bus.collision) begin
          state_n = DEAD;
        end else if (bus.press) begin
          climb_n = CW'(CLIMB_ROWS);
        end else if (tick) begin
          if (row != ROW_W'(ROWS - 1)) row_n = row + ROW_W'(1);
          climb_n = climb_cnt - CW'(1);
          if (climb_cnt == CW'(1)) state_n = RUN;
        end
      end
      DEAD: begin
        if (bus.press) begin
          state_n = IDLE;
          row_n   = ROW_W'(START_ROW);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.bird_row  = row;
  assign bus.playing   = run;
  assign bus.game_over = state == DEAD;
  assign bus.step      = step_q;
endmodule
